phase_scheduler: RTL and testbench
==================================

# phase_scheduler

Four-approach intersection phase scheduler. It replaces the fixed two-way A/B sequencing with demand-driven round-robin arbitration of the single green phase between four approach requesters. It enforces minimum green, maximum green, yellow and all-red clearance times, and supports emergency preemption. It sits between the vehicle-sensor/request inputs and the lamp drivers, alongside the existing counter10/counter5 display counters.

## Interface
Parameters:
- GREEN_MIN, 4: minimum green duration in cycles, ≥1
- GREEN_MAX, 10: maximum green duration in cycles when other approaches wait, ≥GREEN_MIN
- YELLOW_T, 3: yellow duration in cycles, ≥1
- ALLRED_T, 2: all-red clearance duration in cycles, ≥1

Ports:
- CLK  in  1  single clock, all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- req  in  4  level demand per approach, sampled on posedge
- emerg_req  in  1  emergency preemption request, level
- emerg_id  in  2  approach to preempt to; held stable while emerg_req=1
- green  out  4  one-hot or zero, green lamp per approach
- yellow  out  4  one-hot or zero, yellow lamp per approach
- red  out  4  equals ~(green|yellow)
- phase_id  out  2  approach currently or last granted
- grant_pulse  out  1  one-cycle pulse on the first GREEN cycle of a new grant
- emerg_ack  out  1  high while GREEN is held for emerg_id under emerg_req
- timer  out  8  cycles spent in current state, saturates at 255

## Operation
- States: ALLRED, GREEN, YELLOW. Every output is a register.
- Reset (reset_n=0) values, asynchronous:
  - state=ALLRED, timer=0, green=0, yellow=0, red=4'hF
  - phase_id=0, rr_ptr=3, grant_pulse=0, emerg_ack=0
- timer clears to 0 on every state entry and increments each cycle in the state. t denotes the timer value during the current cycle.
- ALLRED:
  - While t+1 < ALLRED_T, stay in ALLRED.
  - Once t+1 ≥ ALLRED_T, arbitrate every cycle:
    - If emerg_req=1, grant emerg_id.
    - Otherwise grant the first set req bit searching rr_ptr+1, rr_ptr+2, … modulo 4.
    - If nothing is granted, remain in ALLRED (rest all-red).
  - On a grant: enter GREEN, phase_id=rr_ptr=granted index, grant_pulse=1 for the next cycle.
- GREEN (approach p=phase_id):
  - Define other = |(req & ~(1<<p)).
  - If emerg_req=1 and emerg_id==p: stay in GREEN, emerg_ack=1.
  - If emerg_req=1 and emerg_id≠p: go to YELLOW immediately. GREEN_MIN is waived.
  - Otherwise go to YELLOW when other=1 and t+1 ≥ GREEN_MIN and (req[p]=0, or t+1 ≥ GREEN_MAX).
  - If other=0, rest in green indefinitely, regardless of GREEN_MAX.
- YELLOW: lasts exactly YELLOW_T cycles, then ALLRED. It is never shortened, including by emergency.
- ALLRED always lasts at least ALLRED_T cycles. It is never shortened.
- Invariants:
  - At most one bit set across green|yellow.
  - No green asserts without a preceding ALLRED of ≥ALLRED_T cycles.
- Simultaneous events:
  - emerg_req beats round-robin.
  - If req changes in the same cycle as an expiry, the sampled value of that cycle decides.
- emerg_req deasserting while GREEN is held for emerg_id: emerg_ack drops next cycle, and normal GREEN exit rules resume with the current t.

## Timing
- Decision and output update take 1 cycle: the state/lamp change is visible on the posedge that ends the deciding cycle.
- A request arriving in rest-all-red reaches green 1 cycle after it is sampled.
- Green durations are counted in cycles with green asserted: exactly max(GREEN_MIN, the cycle the exit condition first holds).
- Yellow lasts exactly YELLOW_T cycles. All-red lasts ALLRED_T cycles plus any rest.
- reset_n assertion mid-phase forces all-red asynchronously, with no yellow. On deassertion, the sequence restarts from ALLRED with rr_ptr=3.

## Test plan
All scenarios use the default parameters.
- **Cold start:** release reset with req=4'b0001 held.
  - Required: red=4'hF for 2 cycles, then green=4'b0001 with grant_pulse for 1 cycle.
  - green stays 4'b0001 for 50+ cycles, since there is no other demand.
- **Max-out and round-robin:** req=4'b1111 held.
  - Required: greens in order 0,1,2,3,0.
  - Each green lasts 10 cycles, each yellow 3 cycles, each all-red 2 cycles. Each grant period is 15 cycles.
- **Gap-out:** green on 0, req[0] dropped at t=1, req[2]=1.
  - Required: green lasts 4 cycles, yellow 3, all-red 2, then green=4'b0100, phase_id=2.
- **Emergency preemption:** green on 1 at t=1, assert emerg_req with emerg_id=3.
  - Required: yellow=4'b0010 on the next cycle (min waived), yellow for 3 cycles, all-red 2, then green=4'b1000 with emerg_ack=1.
  - Green holds while emerg_req=1, even with req=4'b0111.
- **Reset mid-yellow:** pulse reset_n low during yellow on approach 2.
  - Required: immediate red=4'hF, phase_id=0, timer=0.
  - With req=4'b0100 after release: green=4'b0100 after 2 all-red cycles.
- **Idle rest:** req=0 after reset.
  - Required: all-red indefinitely, timer saturates at 255.
  - Asserting req=4'b1000 yields green=4'b1000 on the next cycle.

Source files
------------

// File: rtl/phase_scheduler.sv
// phase_scheduler: round-robin grant of a single green phase across four approaches,
// enforcing min/max green, yellow and all-red clearance, with emergency preemption.
module phase_scheduler #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic       emerg_req,
   input  logic [1:0] emerg_id,
   output logic [3:0] green,
   output logic [3:0] yellow,
   output logic [3:0] red,
   output logic [1:0] phase_id,
   output logic       grant_pulse,
   output logic       emerg_ack,
   output logic [7:0] timer
);
   localparam logic [1:0] S_ALLRED = 2'd0;
   localparam logic [1:0] S_GREEN  = 2'd1;
   localparam logic [1:0] S_YELLOW = 2'd2;
   localparam logic [8:0] L_GMIN   = 9'(GREEN_MIN);
   localparam logic [8:0] L_GMAX   = 9'(GREEN_MAX);
   localparam logic [8:0] L_YT     = 9'(YELLOW_T);
   localparam logic [8:0] L_AR     = 9'(ALLRED_T);

   logic [1:0] r_state, r_rr_ptr;
   logic [8:0] w_t1;
   logic [1:0] w_cand, w_rr_idx, w_gidx, w_next, w_next_phase;
   logic       w_rr_hit, w_other, w_hold, w_green_exit, w_go;

   assign w_t1 = {1'b0, timer} + 9'd1;

   // Scan from the farthest candidate down so the nearest after rr_ptr wins.
   always_comb begin
      w_rr_hit = 1'b0;
      w_rr_idx = 2'd0;
      w_cand   = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         w_cand = r_rr_ptr + 2'(k);
         if (req[w_cand]) begin
            w_rr_hit = 1'b1;
            w_rr_idx = w_cand;
         end
      end
   end

   assign w_gidx       = emerg_req ? emerg_id : w_rr_idx;
   assign w_other      = |(req & ~(4'b0001 << phase_id));
   assign w_hold       = emerg_req && (emerg_id == phase_id);
   assign w_green_exit = emerg_req ? !w_hold
                       : w_other && (w_t1 >= L_GMIN) && (!req[phase_id] || (w_t1 >= L_GMAX));
   assign w_go         = (r_state == S_ALLRED) && (w_t1 >= L_AR) && (emerg_req || w_rr_hit);
   assign w_next       = w_go ? S_GREEN
                       : (r_state == S_GREEN && w_green_exit) ? S_YELLOW
                       : (r_state == S_YELLOW && w_t1 >= L_YT) ? S_ALLRED
                       : r_state;
   assign w_next_phase = w_go ? w_gidx : phase_id;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_ALLRED;
         r_rr_ptr    <= 2'd3;
         timer       <= 8'd0;
         green       <= 4'd0;
         yellow      <= 4'd0;
         red         <= 4'hF;
         phase_id    <= 2'd0;
         grant_pulse <= 1'b0;
         emerg_ack   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_rr_ptr    <= w_go ? w_gidx : r_rr_ptr;
         timer       <= (w_next != r_state) ? 8'd0 : (timer == 8'hFF) ? 8'hFF : timer + 8'd1;
         green       <= (w_next == S_GREEN) ? 4'b0001 << w_next_phase : 4'd0;
         yellow      <= (w_next == S_YELLOW) ? 4'b0001 << w_next_phase : 4'd0;
         red         <= (w_next == S_ALLRED) ? 4'hF : ~(4'b0001 << w_next_phase);
         phase_id    <= w_next_phase;
         grant_pulse <= w_go;
         emerg_ack   <= (w_next == S_GREEN) && emerg_req && (emerg_id == w_next_phase);
      end
   end
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: directed vector table, hand-written corner sequences and a
// randomized run against an abstract cycle model of the phase scheduler.
module tb_phase_scheduler;
   localparam int GREEN_MIN = 4;
   localparam int GREEN_MAX = 10;
   localparam int YELLOW_T  = 3;
   localparam int ALLRED_T  = 2;

   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req = 4'd0;
   logic       emerg_req = 1'b0;
   logic [1:0] emerg_id = 2'd0;
   logic [3:0] green, yellow, red;
   logic [1:0] phase_id;
   logic       grant_pulse, emerg_ack;
   logic [7:0] timer;

   int total = 0;
   int bad = 0;

   phase_scheduler #(
      .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
   ) dut (
      .CLK(CLK), .reset_n(reset_n), .req(req), .emerg_req(emerg_req), .emerg_id(emerg_id),
      .green(green), .yellow(yellow), .red(red), .phase_id(phase_id),
      .grant_pulse(grant_pulse), .emerg_ack(emerg_ack), .timer(timer)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] rq;
      logic       er;
      logic [1:0] ei;
      int         n;
      logic [3:0] g;
      logic [3:0] y;
      logic [1:0] ph;
      logic       gp;
      logic       ack;
      logic [7:0] t;
   } vec_t;

   vec_t vecs[15];

   // Abstract model: 0=all-red, 1=green, 2=yellow; ints and modulo search.
   int m_st, m_t, m_p, m_ptr;
   bit m_pulse, m_ack;

   function automatic void model_reset();
      m_st = 0; m_t = 0; m_p = 0; m_ptr = 3; m_pulse = 0; m_ack = 0;
   endfunction

   function automatic void model_step(logic [3:0] rq, logic er, logic [1:0] ei);
      int ns = m_st;
      int np = m_p;
      int g = -1;
      bit other;
      if (m_st == 0 && m_t + 1 >= ALLRED_T) begin
         if (er) g = int'(ei);
         else for (int k = 1; k <= 4; k++) if (g < 0 && rq[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
         if (g >= 0) begin ns = 1; np = g; end
      end else if (m_st == 1) begin
         other = (rq & ~(4'b0001 << m_p)) != 4'd0;
         if (er) begin
            if (int'(ei) != m_p) ns = 2;
         end else if (other && m_t + 1 >= GREEN_MIN && (!rq[m_p] || m_t + 1 >= GREEN_MAX)) ns = 2;
      end else if (m_st == 2 && m_t + 1 >= YELLOW_T) ns = 0;
      m_pulse = (m_st == 0 && ns == 1);
      m_t = (ns != m_st) ? 0 : (m_t < 255 ? m_t + 1 : 255);
      m_ack = (ns == 1) && er && (int'(ei) == np);
      m_st = ns;
      m_p = np;
      if (g >= 0 && ns == 1) m_ptr = g;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic rst_with(input logic [3:0] rq, input logic er, input logic [1:0] ei);
      @(negedge CLK);
      reset_n = 1'b0;
      req = rq; emerg_req = er; emerg_id = ei;
      model_reset();
      @(negedge CLK);
      reset_n = 1'b1;
   endtask

   logic [3:0] eg, ey;

   initial begin
      vecs[0]  = '{4'b0001, 1'b0, 2'd0,   1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd1};
      vecs[1]  = '{4'b0001, 1'b0, 2'd0,   2, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd0};
      vecs[2]  = '{4'b0001, 1'b0, 2'd0,   3, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd1};
      vecs[3]  = '{4'b0001, 1'b0, 2'd0,  60, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd58};
      vecs[4]  = '{4'b0000, 1'b0, 2'd0, 300, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd255};
      vecs[5]  = '{4'b1111, 1'b0, 2'd0,   2, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd0};
      vecs[6]  = '{4'b1111, 1'b0, 2'd0,  12, 4'b0000, 4'b0001, 2'd0, 1'b0, 1'b0, 8'd0};
      vecs[7]  = '{4'b1111, 1'b0, 2'd0,  15, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{4'b1111, 1'b0, 2'd0,  17, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0, 8'd0};
      vecs[9]  = '{4'b1111, 1'b0, 2'd0,  27, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b0, 8'd0};
      vecs[10] = '{4'b1111, 1'b0, 2'd0,  32, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0, 8'd0};
      vecs[11] = '{4'b1111, 1'b0, 2'd0,  47, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0, 8'd0};
      vecs[12] = '{4'b1111, 1'b0, 2'd0,  62, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd0};
      vecs[13] = '{4'b0000, 1'b1, 2'd2,   2, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 8'd0};
      vecs[14] = '{4'b1111, 1'b1, 2'd2,  40, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1, 8'd38};

      @(negedge CLK);
      #1;
      check("reset_red", 32'(red), 32'hF);
      check("reset_state", 32'({green, yellow, phase_id, grant_pulse, emerg_ack, timer}), 32'd0);

      foreach (vecs[i]) begin
         rst_with(vecs[i].rq, vecs[i].er, vecs[i].ei);
         adv(vecs[i].n);
         check($sformatf("vec%0d_lamps", i), 32'({green, yellow, red}),
               32'({vecs[i].g, vecs[i].y, ~(vecs[i].g | vecs[i].y)}));
         check($sformatf("vec%0d_ctl", i), 32'({phase_id, grant_pulse, emerg_ack, timer}),
               32'({vecs[i].ph, vecs[i].gp, vecs[i].ack, vecs[i].t}));
      end

      // Gap-out: demand on 0 drops at t=1 while 2 waits.
      rst_with(4'b0001, 1'b0, 2'd0);
      adv(3);
      req = 4'b0100;
      adv(2);
      check("gap_still_green", 32'({green, timer}), 32'({4'b0001, 8'd3}));
      adv(1);
      check("gap_yellow", 32'(yellow), 32'h1);
      adv(3);
      check("gap_allred", 32'(red), 32'hF);
      adv(2);
      check("gap_green2", 32'({green, phase_id, grant_pulse}), 32'({4'b0100, 2'd2, 1'b1}));

      // Emergency preemption from green on 1 at t=1.
      rst_with(4'b0010, 1'b0, 2'd0);
      adv(3);
      emerg_req = 1'b1; emerg_id = 2'd3;
      adv(1);
      check("em_yellow", 32'({green, yellow}), 32'({4'b0000, 4'b0010}));
      adv(2);
      check("em_yellow_end", 32'({yellow, timer}), 32'({4'b0010, 8'd2}));
      adv(1);
      check("em_allred", 32'({red, yellow}), 32'({4'hF, 4'b0000}));
      adv(1);
      check("em_allred2", 32'({red, timer}), 32'({4'hF, 8'd1}));
      adv(1);
      check("em_green", 32'({green, emerg_ack, grant_pulse}), 32'({4'b1000, 1'b1, 1'b1}));
      req = 4'b0111;
      adv(20);
      check("em_hold", 32'({green, emerg_ack}), 32'({4'b1000, 1'b1}));
      emerg_req = 1'b0;
      adv(1);
      check("em_release", 32'({yellow, emerg_ack}), 32'({4'b1000, 1'b0}));

      // Asynchronous reset in the middle of yellow on approach 2.
      rst_with(4'b0100, 1'b0, 2'd0);
      adv(2);
      req = 4'b0001;
      adv(4);
      check("ry_yellow", 32'(yellow), 32'h4);
      adv(1);
      reset_n = 1'b0;
      #1;
      check("ry_async", 32'({red, yellow, green, phase_id, timer}), 32'({4'hF, 4'h0, 4'h0, 2'd0, 8'd0}));
      req = 4'b0100;
      @(negedge CLK);
      reset_n = 1'b1;
      adv(1);
      check("ry_allred", 32'(red), 32'hF);
      adv(1);
      check("ry_green", 32'({green, phase_id}), 32'({4'b0100, 2'd2}));

      // Idle rest with timer saturation, then a late request.
      rst_with(4'b0000, 1'b0, 2'd0);
      adv(300);
      check("idle_sat", 32'({red, timer}), 32'({4'hF, 8'd255}));
      req = 4'b1000;
      adv(1);
      check("idle_wake", 32'({green, phase_id, grant_pulse}), 32'({4'b1000, 2'd3, 1'b1}));

      // Randomized run against the abstract model.
      rst_with(4'b0000, 1'b0, 2'd0);
      for (int c = 0; c < 4000; c++) begin
         @(posedge CLK);
         model_step(req, emerg_req, emerg_id);
         @(negedge CLK);
         eg = (m_st == 1) ? 4'(1 << m_p) : 4'd0;
         ey = (m_st == 2) ? 4'(1 << m_p) : 4'd0;
         check("rand", 32'({green, yellow, red, phase_id, grant_pulse, emerg_ack, timer}),
               32'({eg, ey, ~(eg | ey), 2'(m_p), m_pulse, m_ack, 8'(m_t)}));
         if ($urandom_range(0, 7) == 0) req = 4'($urandom);
         if (!emerg_req && $urandom_range(0, 99) == 0) begin
            emerg_req = 1'b1;
            emerg_id = 2'($urandom);
         end else if (emerg_req && $urandom_range(0, 29) == 0) emerg_req = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
